// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the pipeline MEM
// stage and a debug/loader port. The core has priority. A starvation counter
// forces one debug grant after MAX_WAIT denied cycles and stalls the core for
// that cycle.
// Optional build macro DMEM_ARB_STATS_EN adds saturating stall/grant counters.
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int MAX_WAIT   = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_rd,
    input  logic                  core_wr,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [2:0]            core_funct3,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  core_stall,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]      stat_stall_cnt,
    output logic [CNT_W-1:0]      stat_dbg_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_CORE, S_DBG, S_FORCE} state_t;

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    state_t      state, sel;
    logic [3:0]  wait_cnt;
    logic        dbg_we_q;
    logic        core_busy;

    assign core_busy = core_rd | core_wr;

    // State register: remembers last cycle's selection (drives dbg_rvalid)
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= sel;
    end

    // Selection for this cycle, purely from current inputs and wait_cnt
    always_comb begin
        sel = S_IDLE;
        if (reset)
            sel = S_IDLE;
        else if (dbg_req && core_busy && wait_cnt == MAX_W)
            sel = S_FORCE;
        else if (core_busy)
            sel = S_CORE;
        else if (dbg_req)
            sel = S_DBG;
    end

    // Memory mux and handshake outputs for the selected requester
    always_comb begin
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = core_addr;
        mem_wdata  = core_wdata;
        mem_funct3 = core_funct3;
        core_rdata = '0;
        core_stall = 1'b0;
        dbg_gnt    = 1'b0;
        case (sel)
            S_CORE: begin
                // A write wins when the core asserts both strobes
                mem_wr     = core_wr;
                mem_rd     = core_rd & ~core_wr;
                core_rdata = mem_rdata;
            end
            S_DBG, S_FORCE: begin
                mem_rd     = ~dbg_we;
                mem_wr     = dbg_we;
                mem_addr   = dbg_addr;
                mem_wdata  = dbg_wdata;
                mem_funct3 = 3'b010;
                dbg_gnt    = 1'b1;
                core_stall = (sel == S_FORCE);
            end
            default: ;
        endcase
    end

    // Starvation counter: counts consecutive denied debug cycles
    always_ff @(posedge clk) begin
        if (reset || !dbg_req || dbg_gnt)
            wait_cnt <= '0;
        else if (sel == S_CORE && wait_cnt != MAX_W)
            wait_cnt <= wait_cnt + 4'd1;
    end

    // Debug read capture; the grant type is kept to qualify dbg_rvalid
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_rdata <= '0;
            dbg_we_q  <= 1'b0;
        end else if (dbg_gnt) begin
            dbg_we_q <= dbg_we;
            if (!dbg_we) dbg_rdata <= mem_rdata;
        end
    end

    assign dbg_rvalid = (state == S_DBG || state == S_FORCE) && !dbg_we_q;

`ifdef DMEM_ARB_STATS_EN
    // Saturating event counters for stalls and debug grants
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_stall_cnt <= '0;
            stat_dbg_cnt   <= '0;
        end else begin
            if (core_stall && stat_stall_cnt != '1) stat_stall_cnt <= stat_stall_cnt + 1'b1;
            if (dbg_gnt && stat_dbg_cnt != '1)      stat_dbg_cnt   <= stat_dbg_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a reference model that tracks
// consecutive denied debug cycles and a golden copy of the memory contents.
module tb_dmem_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          core_rd = 0, core_wr = 0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic [2:0]    core_funct3 = '0;
    logic [DW-1:0] core_rdata;
    logic          core_stall;
    logic          dbg_req = 0, dbg_we = 0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          dbg_gnt, dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_funct3;
    logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]   stat_stall_cnt, stat_dbg_cnt;
`endif

    dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .MAX_WAIT(MW), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_funct3(core_funct3),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .stat_stall_cnt(stat_stall_cnt), .stat_dbg_cnt(stat_dbg_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural single-port data memory driven by the arbiter
    logic [DW-1:0] dm [0:511];
    always @(posedge clk) if (mem_wr) dm[mem_addr] <= mem_wdata;
    assign mem_rdata = mem_rd ? dm[mem_addr] : '0;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [DW-1:0] gold [0:511];
    int            denied = 0;
    int            dut_wait = 0;
    bit            exp_rv = 0;
    logic [DW-1:0] exp_rd = '0;
    bit            seen_gnt = 0, seen_stall = 0;

    // Compare process: every negedge, evaluate the spec rules on current inputs
    always @(negedge clk) begin
        bit busy, frc, gnt, nxt_rv;
        chk("dbg_rvalid", dbg_rvalid, exp_rv);
        if (exp_rv) chk("dbg_rdata", dbg_rdata, exp_rd);
        busy = core_rd | core_wr;
        nxt_rv = 0;
        if (reset) begin
            chk("rst_gnt", dbg_gnt, 0);
            chk("rst_stall", core_stall, 0);
            chk("rst_mem_rd", mem_rd, 0);
            chk("rst_mem_wr", mem_wr, 0);
            denied = 0;
            dut_wait = 0;
        end else begin
            frc = dbg_req && busy && (denied >= MW);
            gnt = dbg_req && (!busy || frc);
            chk("dbg_gnt", dbg_gnt, gnt);
            chk("core_stall", core_stall, frc);
            if (gnt) begin
                chk("g_mem_rd", mem_rd, !dbg_we);
                chk("g_mem_wr", mem_wr, dbg_we);
                chk("g_mem_addr", mem_addr, dbg_addr);
                chk("g_funct3", mem_funct3, 3'b010);
                if (dbg_we) begin
                    chk("g_wdata", mem_wdata, dbg_wdata);
                    gold[dbg_addr] = dbg_wdata;
                end else begin
                    exp_rd = gold[dbg_addr];
                    nxt_rv = 1;
                end
            end
            if (frc) begin
                chk("force_rdata", core_rdata, 0);
            end else if (busy) begin
                chk("c_mem_wr", mem_wr, core_wr);
                chk("c_mem_rd", mem_rd, core_rd && !core_wr);
                chk("c_mem_addr", mem_addr, core_addr);
                chk("c_funct3", mem_funct3, core_funct3);
                if (core_wr) begin
                    chk("c_wdata", mem_wdata, core_wdata);
                    gold[core_addr] = core_wdata;
                end else begin
                    chk("c_rdata", core_rdata, gold[core_addr]);
                end
            end else if (!gnt) begin
                chk("idle_mem_rd", mem_rd, 0);
                chk("idle_mem_wr", mem_wr, 0);
            end
            denied = (dbg_req && !gnt) ? denied + 1 : 0;
            // Latency bound measured on the DUT's own grant
            dut_wait = (dbg_req && !dbg_gnt) ? dut_wait + 1 : 0;
            chk("dbg_latency", dut_wait <= MW, 1);
        end
        exp_rv = nxt_rv;
        seen_gnt = dbg_gnt;
        seen_stall = core_stall;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        core_rd = 0; core_wr = 0; dbg_req = 0; dbg_we = 0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            dm[i] = '0;
            gold[i] = '0;
        end
        repeat (2) step();
        reset = 0;

        // 1: idle after reset
        for (int c = 0; c < 10; c++) begin
            #2;
            if (c == 0) begin
                chk("s1_rvalid", dbg_rvalid, 0);
                chk("s1_rdata", dbg_rdata, 0);
                chk("s1_gnt", dbg_gnt, 0);
                chk("s1_stall", core_stall, 0);
            end
            chk("s1_mem_rd", mem_rd, 0);
            chk("s1_mem_wr", mem_wr, 0);
            step();
        end

        // 2: debug write then read back
        dbg_req = 1; dbg_we = 1; dbg_addr = 9'h010; dbg_wdata = 32'hDEADBEEF;
        #2;
        chk("s2_gnt", dbg_gnt, 1);
        chk("s2_mem_wr", mem_wr, 1);
        chk("s2_funct3", mem_funct3, 3'b010);
        step();
        dbg_we = 0;
        #2;
        chk("s2_rd_gnt", dbg_gnt, 1);
        chk("s2_mem_rd", mem_rd, 1);
        step();
        dbg_req = 0;
        #2;
        chk("s2_rvalid", dbg_rvalid, 1);
        chk("s2_rdata", dbg_rdata, 32'hDEADBEEF);
        step();

        // 3: preload then core load
        dbg_req = 1; dbg_we = 1; dbg_addr = 9'h020; dbg_wdata = 32'h12345678;
        step();
        dbg_req = 0; core_rd = 1; core_addr = 9'h020; core_funct3 = 3'b010;
        #2;
        chk("s3_rdata", core_rdata, 32'h12345678);
        chk("s3_stall", core_stall, 0);
        step();
        idle_all();
        step();

        // 4: sustained contention
        core_rd = 1; core_addr = 9'h020;
        dbg_req = 1; dbg_we = 0; dbg_addr = 9'h010;
        for (int c = 0; c < 4; c++) begin
            #2;
            chk("s4_wait_gnt", dbg_gnt, 0);
            chk("s4_wait_rdata", core_rdata, 32'h12345678);
            step();
        end
        #2;
        chk("s4_force_gnt", dbg_gnt, 1);
        chk("s4_force_stall", core_stall, 1);
        chk("s4_force_rdata", core_rdata, 0);
        step();
        dbg_req = 0;
        #2;
        chk("s4_replay_stall", core_stall, 0);
        chk("s4_replay_rdata", core_rdata, 32'h12345678);
        chk("s4_rvalid", dbg_rvalid, 1);
        chk("s4_dbg_rdata", dbg_rdata, 32'hDEADBEEF);
        step();
        idle_all();
        step();

        // 5: simultaneous read and write strobes
        core_rd = 1; core_wr = 1; core_addr = 9'h030; core_wdata = 32'hA5A5A5A5;
        #2;
        chk("s5_mem_wr", mem_wr, 1);
        chk("s5_mem_rd", mem_rd, 0);
        step();
        core_wr = 0;
        #2;
        chk("s5_readback", core_rdata, 32'hA5A5A5A5);
        step();
        idle_all();
        step();

        // 6: reset in the forced-grant cycle
        core_rd = 1; core_addr = 9'h020;
        dbg_req = 1; dbg_we = 0; dbg_addr = 9'h010;
        repeat (4) step();
        reset = 1;
        #2;
        chk("s6_rst_gnt", dbg_gnt, 0);
        step();
        reset = 0;
        #2;
        chk("s6_stall", core_stall, 0);
        chk("s6_rvalid", dbg_rvalid, 0);
`ifdef DMEM_ARB_STATS_EN
        chk("s6_stat_stall", stat_stall_cnt, 0);
`endif
        for (int c = 0; c < 4; c++) begin
            if (c > 0) #2;
            chk("s6_wait_gnt", dbg_gnt, 0);
            step();
        end
        #2;
        chk("s6_force_gnt", dbg_gnt, 1);
        chk("s6_force_stall", core_stall, 1);
        step();
        idle_all();
        step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            if (!seen_stall) begin
                core_rd = ($urandom_range(0, 2) != 0);
                core_wr = ($urandom_range(0, 3) == 0);
                core_addr = AW'($urandom_range(0, 15));
                core_wdata = $urandom;
                core_funct3 = 3'($urandom_range(0, 7));
            end
            if (!dbg_req || seen_gnt) begin
                dbg_req = ($urandom_range(0, 2) != 0);
                dbg_we = $urandom_range(0, 1);
                dbg_addr = AW'($urandom_range(0, 15));
                dbg_wdata = $urandom;
            end
            step();
        end
        reset = 0;
        idle_all();
        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
